spi_capture: RTL and testbench

SPI_CAPTURE -- requirements
Module: spi_capture

---
 rtl/spi_capture_if.sv | 27 ++
 rtl/spi_capture.sv | 154 +++++++++++++++
 tb/tb_spi_capture.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_capture_if.sv
// spi_capture_if: bundles the monitored SPI lines and the captured-word handshake.
// Signals: spi_clk/spi_cs/spi_di/spi_do (monitored bus), wordReady (consumer accept),
//          wordValid/word_di/word_do (held word pair), frameErr/overflow (pulses), errCnt.
// master drives the SPI lines and wordReady; slave is the capture block.
interface spi_capture_if;
  logic        spi_clk;
  logic        spi_cs;
  logic        spi_di;
  logic        spi_do;
  logic        wordReady;
  logic        wordValid;
  logic [31:0] word_di;
  logic [31:0] word_do;
  logic        frameErr;
  logic        overflow;
  logic [7:0]  errCnt;

  modport master (
    output spi_clk, spi_cs, spi_di, spi_do, wordReady,
    input  wordValid, word_di, word_do, frameErr, overflow, errCnt
  );

  modport slave (
    input  spi_clk, spi_cs, spi_di, spi_do, wordReady,
    output wordValid, word_di, word_do, frameErr, overflow, errCnt
  );
endinterface

// File: rtl/spi_capture.sv
// spi_capture: passive SPI monitor capturing 32-bit frames of two data lines into a one-deep holding register.
// Latency: frame-end event is registered 2 clk edges after spi_cs is first sampled high.
// Backpressure: valid/ready; a good frame arriving while the held word is not taken is dropped with an overflow pulse.
// Ports: clk, rst (synchronous, active-high); bus (spi_capture_if.slave) carries SPI inputs,
//        wordReady in, wordValid/word_di/word_do/frameErr/overflow/errCnt out.
// Optional feature: define SPIMON_ERR_CNT_EN to build the saturating error counter on errCnt;
//        without it errCnt is tied to zero.
module spi_capture (
  input  logic         clk,
  input  logic         rst,
  spi_capture_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  state_t      state_q;

  // [0] first sync flop, [1] second sync flop, [2] history flop for edge detection
  logic [2:0]  sclk_sync_q;
  logic [2:0]  cs_sync_q;
  logic [2:0]  di_sync_q;
  logic [2:0]  do_sync_q;

  logic [31:0] sh_di_q;
  logic [31:0] sh_do_q;
  logic [5:0]  bitcnt_q;
  logic [5:0]  bitcnt_d;

  logic [31:0] word_di_q;
  logic [31:0] word_do_q;
  logic        wvld_q;
  logic        frame_err_q;
  logic        ovf_q;

  logic        sclk_rise;
  logic        cs_rise;
  logic        cs_fall;
  logic        cs_low;
  logic        xfer;
  logic        frame_good;

  assign sclk_rise  = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign cs_rise    = cs_sync_q[1]   & ~cs_sync_q[2];
  assign cs_fall    = ~cs_sync_q[1]  &  cs_sync_q[2];
  assign cs_low     = ~cs_sync_q[1];
  assign xfer       = wvld_q & bus.wordReady;
  assign frame_good = (bitcnt_q == 6'd32);

  // Bit counter saturates so very long frames cannot wrap back to 32.
  assign bitcnt_d = (bitcnt_q == 6'd63) ? 6'd63 : bitcnt_q + 6'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      di_sync_q   <= '0;
      do_sync_q   <= '0;
      sh_di_q     <= '0;
      sh_do_q     <= '0;
      bitcnt_q    <= '0;
      word_di_q   <= '0;
      word_do_q   <= '0;
      wvld_q      <= 1'b0;
      frame_err_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], bus.spi_clk};
      cs_sync_q   <= {cs_sync_q[1:0],   bus.spi_cs};
      di_sync_q   <= {di_sync_q[1:0],   bus.spi_di};
      do_sync_q   <= {do_sync_q[1:0],   bus.spi_do};

      frame_err_q <= 1'b0;
      ovf_q       <= 1'b0;

      // Consumer took the word; a load below on the same edge overrides this.
      if (xfer) begin
        wvld_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            bitcnt_q <= '0;
            sh_di_q  <= '0;
            sh_do_q  <= '0;
            state_q  <= ST_ARMED;
          end
        end

        ST_ARMED: begin
          if (cs_fall) begin
            // Only reachable after a glitch pair; treat as a fresh frame start.
            bitcnt_q <= '0;
            sh_di_q  <= '0;
            sh_do_q  <= '0;
          end else if (cs_rise) begin
            state_q <= ST_IDLE;
            if (frame_good) begin
              if (!wvld_q || xfer) begin
                word_di_q <= sh_di_q;
                word_do_q <= sh_do_q;
                wvld_q    <= 1'b1;
              end else begin
                ovf_q <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
            end
          end else if (sclk_rise && cs_low) begin
            // Data is taken from the history flop: it was sampled one cycle
            // before the rise was seen, well after the preceding falling edge
            // (spi_clk is at most clk/4), so it is settled and aligned.
            sh_di_q  <= {sh_di_q[30:0], di_sync_q[2]};
            sh_do_q  <= {sh_do_q[30:0], do_sync_q[2]};
            bitcnt_q <= bitcnt_d;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.wordValid = wvld_q;
  assign bus.word_di   = word_di_q;
  assign bus.word_do   = word_do_q;
  assign bus.frameErr  = frame_err_q;
  assign bus.overflow  = ovf_q;

`ifdef SPIMON_ERR_CNT_EN
  logic [7:0] errcnt_q;
  logic [7:0] errcnt_d;

  // frameErr and overflow never coincide, so one increment per pulse suffices.
  assign errcnt_d = (errcnt_q == 8'hFF) ? 8'hFF : errcnt_q + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      errcnt_q <= '0;
    end else if (frame_err_q || ovf_q) begin
      errcnt_q <= errcnt_d;
    end
  end

  assign bus.errCnt = errcnt_q;
`else
  assign bus.errCnt = 8'h00;
`endif

endmodule

// File: tb/tb_spi_capture.sv
// tb_spi_capture: drives SPI frames into spi_capture and checks against a frame-level model.
// The model tracks expected words (queue), frameErr/overflow counts and the error count.
module tb_spi_capture;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  spi_capture_if bus ();

  spi_capture dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  logic [63:0] exp_q[$];
  int          exp_fe     = 0;
  int          exp_ovf    = 0;
  int          model_errs = 0;
  bit          model_full = 0;

  // Observed state
  int          got_fe   = 0;
  int          got_ovf  = 0;
  int          spurious = 0;
  logic        prev_vld, prev_xfer, prev_fe, prev_ovf;
  logic [31:0] prev_di, prev_do;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_errcnt();
`ifdef SPIMON_ERR_CNT_EN
    return 32'(model_errs);
`else
    return 32'd0;
`endif
  endfunction

  function automatic void bump_err();
    if (model_errs < 255) model_errs++;
  endfunction

  // Frame-level rule: wrong length -> error; good while holding full -> overflow; else a new word.
  function automatic void model_frame(input int nbits, input logic [31:0] dv, input logic [31:0] ov);
    if (nbits != 32) begin
      exp_fe++;
      bump_err();
    end else if (model_full) begin
      exp_ovf++;
      bump_err();
    end else begin
      exp_q.push_back({dv, ov});
      model_full = !bus.wordReady;
    end
  endfunction

  task automatic begin_frame(input int half);
    bus.spi_cs = 1'b0;
    wait_clks(half);
  endtask

  task automatic send_bits(input int first, input int n, input logic [31:0] dv,
                           input logic [31:0] ov, input int half);
    int idx;
    for (int i = first; i < first + n; i++) begin
      idx        = 31 - (i % 32);
      bus.spi_di = dv[idx];
      bus.spi_do = ov[idx];
      wait_clks(half);
      bus.spi_clk = 1'b1;
      wait_clks(half);
      bus.spi_clk = 1'b0;
    end
  endtask

  task automatic end_frame(input int half);
    wait_clks(half);
    bus.spi_cs = 1'b1;
  endtask

  task automatic send_frame(input int nbits, input logic [31:0] dv, input logic [31:0] ov,
                            input int half);
    begin_frame(half);
    send_bits(0, nbits, dv, ov, half);
    end_frame(half);
  endtask

  // Monitor: transfers, pulse widths, exclusivity and hold stability.
  always @(negedge clk) begin
    logic [63:0] w;
    if (rst) begin
      prev_vld  = 1'b0;
      prev_xfer = 1'b0;
      prev_fe   = 1'b0;
      prev_ovf  = 1'b0;
      prev_di   = '0;
      prev_do   = '0;
    end else begin
      if (bus.frameErr || bus.overflow)
        check("fe_ovf_excl", 32'(bus.frameErr & bus.overflow), 32'd0);
      if (bus.frameErr) begin
        got_fe++;
        check("fe_one_cycle", 32'(prev_fe), 32'd0);
      end
      if (bus.overflow) begin
        got_ovf++;
        check("ovf_one_cycle", 32'(prev_ovf), 32'd0);
      end
      if (prev_vld && !prev_xfer) begin
        check("hold_vld", 32'(bus.wordValid), 32'd1);
        check("hold_di", bus.word_di, prev_di);
        check("hold_do", bus.word_do, prev_do);
      end
      if (bus.wordValid && bus.wordReady) begin
        if (exp_q.size() == 0) begin
          spurious++;
        end else begin
          w = exp_q.pop_front();
          check("word_di", bus.word_di, w[63:32]);
          check("word_do", bus.word_do, w[31:0]);
        end
      end
      prev_vld  = bus.wordValid;
      prev_xfer = bus.wordValid & bus.wordReady;
      prev_fe   = bus.frameErr;
      prev_ovf  = bus.overflow;
      prev_di   = bus.word_di;
      prev_do   = bus.word_do;
    end
  end

  initial begin
    logic [31:0] dv, ov;
    int nb, hp;

    rst           = 1'b1;
    bus.spi_clk   = 1'b0;
    bus.spi_cs    = 1'b1;
    bus.spi_di    = 1'b0;
    bus.spi_do    = 1'b0;
    bus.wordReady = 1'b0;
    wait_clks(4);

    // Reset state
    check("rst_vld", 32'(bus.wordValid), 32'd0);
    check("rst_di", bus.word_di, 32'd0);
    check("rst_do", bus.word_do, 32'd0);
    check("rst_fe", 32'(bus.frameErr), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    check("rst_errcnt", 32'(bus.errCnt), 32'd0);
    rst = 1'b0;
    wait_clks(4);

    // Single frame at clk/4, including frame-end latency
    bus.wordReady = 1'b1;
    model_frame(32, 32'h0000_0001, 32'h8000_0000);
    send_frame(32, 32'h0000_0001, 32'h8000_0000, 2);
    wait_clks(2);
    check("lat_vld_e1", 32'(bus.wordValid), 32'd0);
    wait_clks(1);
    check("lat_vld_e2", 32'(bus.wordValid), 32'd1);
    wait_clks(6);

    // Eight back-to-back frames
    for (int k = 0; k < 8; k++) begin
      dv = 32'(k + 1);
      ov = {8'(8'h80 + k), 24'h0};
      model_frame(32, dv, ov);
      send_frame(32, dv, ov, 2);
      wait_clks(6);
    end
    check("b2b_drained", 32'(exp_q.size()), 32'd0);

    // Short then long frame
    model_frame(31, 32'hFFFF_FFFF, 32'h1234_5678);
    send_frame(31, 32'hFFFF_FFFF, 32'h1234_5678, 2);
    wait_clks(2);
    check("lat_fe_e1", 32'(bus.frameErr), 32'd0);
    wait_clks(1);
    check("lat_fe_e2", 32'(bus.frameErr), 32'd1);
    wait_clks(6);
    model_frame(33, 32'hFFFF_FFFF, 32'h1234_5678);
    send_frame(33, 32'hFFFF_FFFF, 32'h1234_5678, 2);
    wait_clks(8);
    check("len_fe_count", 32'(got_fe), 32'(exp_fe));
    check("len_errcnt", 32'(bus.errCnt), exp_errcnt());

    // Held word, second frame overflows, then deliver only the first
    bus.wordReady = 1'b0;
    model_frame(32, 32'hA5A5_A5A5, 32'h5A5A_5A5A);
    send_frame(32, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 2);
    wait_clks(8);
    model_frame(32, 32'h5A5A_5A5A, 32'hA5A5_A5A5);
    send_frame(32, 32'h5A5A_5A5A, 32'hA5A5_A5A5, 3);
    wait_clks(8);
    check("ovf_held_vld", 32'(bus.wordValid), 32'd1);
    check("ovf_held_di", bus.word_di, 32'hA5A5_A5A5);
    check("ovf_count", 32'(got_ovf), 32'(exp_ovf));
    bus.wordReady = 1'b1;
    model_full    = 0;
    wait_clks(4);
    check("ovf_drained_vld", 32'(bus.wordValid), 32'd0);
    check("ovf_drained_q", 32'(exp_q.size()), 32'd0);
    check("ovf_errcnt", 32'(bus.errCnt), exp_errcnt());

    // Transfer on the same edge as a good frame load
    bus.wordReady = 1'b0;
    model_frame(32, 32'hC3C3_0001, 32'h0F0F_0001);
    send_frame(32, 32'hC3C3_0001, 32'h0F0F_0001, 2);
    wait_clks(8);
    model_full = 0;
    model_frame(32, 32'h3C3C_0002, 32'hF0F0_0002);
    send_frame(32, 32'h3C3C_0002, 32'hF0F0_0002, 2);
    wait_clks(2);
    bus.wordReady = 1'b1;
    model_full    = 0;
    wait_clks(1);
    check("coin_vld", 32'(bus.wordValid), 32'd1);
    check("coin_di", bus.word_di, 32'h3C3C_0002);
    check("coin_ovf", 32'(bus.overflow), 32'd0);
    wait_clks(4);
    check("coin_ovf_count", 32'(got_ovf), 32'(exp_ovf));

    // Reset mid-frame: frame abandoned, next frame captured
    begin_frame(2);
    send_bits(0, 16, 32'hDEAD_BEEF, 32'hCAFE_F00D, 2);
    rst = 1'b1;
    wait_clks(1);
    rst        = 1'b0;
    model_errs = 0;
    model_full = 0;
    send_bits(16, 16, 32'hDEAD_BEEF, 32'hCAFE_F00D, 2);
    end_frame(2);
    wait_clks(3);
    check("rst_mid_no_fe", 32'(bus.frameErr), 32'd0);
    check("rst_mid_no_vld", 32'(bus.wordValid), 32'd0);
    check("rst_mid_errcnt", 32'(bus.errCnt), 32'd0);
    wait_clks(4);
    model_frame(32, 32'h1234_5678, 32'h9ABC_DEF0);
    send_frame(32, 32'h1234_5678, 32'h9ABC_DEF0, 2);
    wait_clks(8);
    check("rst_next_q", 32'(exp_q.size()), 32'd0);

    // Randomized frames: lengths, data, spi_clk rate, idle spi_clk toggles
    for (int k = 0; k < 24; k++) begin
      nb = ($urandom_range(0, 2) != 0) ? 32 : int'($urandom_range(1, 70));
      hp = int'($urandom_range(2, 4));
      dv = $urandom;
      ov = $urandom;
      model_frame(nb, dv, ov);
      send_frame(nb, dv, ov, hp);
      wait_clks(int'($urandom_range(6, 12)));
      for (int t = 0; t < int'($urandom_range(0, 3)); t++) begin
        bus.spi_clk = 1'b1;
        wait_clks(2);
        bus.spi_clk = 1'b0;
        wait_clks(2);
      end
    end
    wait_clks(10);

    check("final_q_empty", 32'(exp_q.size()), 32'd0);
    check("final_spurious", 32'(spurious), 32'd0);
    check("final_fe_count", 32'(got_fe), 32'(exp_fe));
    check("final_ovf_count", 32'(got_ovf), 32'(exp_ovf));
    check("final_errcnt", 32'(bus.errCnt), exp_errcnt());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
